// File: rtl/video_timing_fetch.sv
// video_timing_fetch
// Pixel-clock video timing generator with frame-buffer read-address generation
// and Bayer mosaicing of the returned pixel data.
//
// A free-running x/y raster counter feeds a registered timing stage that
// issues one read request per active pixel (rd_en/rd_addr). The sync, DE and
// pixel-parity information travel down a control pipeline that is RD_LAT
// stages deep, so they sit beside the memory data when that data is sampled.
// One more register applies the mosaic and drives the outputs, which keeps
// sync, DE and RGB exactly aligned.
//
// Ports:
//   clk_low              pixel clock
//   reset                asynchronous active-low reset
//   en                   run enable; low clears everything synchronously
//   mode[2:0]            0 passthrough, 1 RGGB, 2 GRBG, 3 GBRG, 4 BGGR, 5-7 black
//   rd_en, rd_addr       pixel read request and address to pixel memory
//   pix_r/g/b            memory read data, sampled RD_LAT cycles after rd_en
//   out_r/g/b            mosaiced pixel, zero outside active video
//   out_hsync/out_vsync  syncs, active level HS_POL / VS_POL
//   out_de               active video
//   frame_start          one-cycle pulse on the first DE of a frame
//   line_start           one-cycle pulse on the first DE of each line
module video_timing_fetch #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   DATA_W      = 8,
  parameter int   ADDR_W      = 21,
  parameter int   ADDR_BASE   = 0,
  parameter int   LINE_STRIDE = H_ACTIVE,
  parameter int   RD_LAT      = 2
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] pix_r,
  input  logic [DATA_W-1:0] pix_g,
  input  logic [DATA_W-1:0] pix_b,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_de,
  output logic              frame_start,
  output logic              line_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One spare count so every boundary up to and including H_TOT/V_TOT fits.
  localparam int XW = $clog2(H_TOT + 1);
  localparam int YW = $clog2(V_TOT + 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOT - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [YW-1:0] Y_LAST = YW'(V_TOT - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_STRIDE);

  localparam logic [1:0] CH_R    = 2'd0;
  localparam logic [1:0] CH_G    = 2'd1;
  localparam logic [1:0] CH_B    = 2'd2;
  localparam logic [1:0] CH_NONE = 2'd3;

  // Everything the output stage needs to know about one request. hs/vs are
  // "active" flags; polarity is applied only at the pins so that an all-zero
  // pipeline means inactive syncs.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
    logic       y0;
    logic       x0;
    logic [2:0] pat;
  } ctl_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        mode_lat_q, mode_lat_d;

  // pipe_q[0] is the timing stage (drives rd_en); pipe_q[RD_LAT] lines up
  // with the sampled memory data in pix_*_q.
  ctl_t [RD_LAT:0]   pipe_q, pipe_d;

  logic [DATA_W-1:0] pix_r_q, pix_r_d;
  logic [DATA_W-1:0] pix_g_q, pix_g_d;
  logic [DATA_W-1:0] pix_b_q, pix_b_d;

  logic [DATA_W-1:0] out_r_q, out_r_d;
  logic [DATA_W-1:0] out_g_q, out_g_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic              out_hs_q, out_hs_d;
  logic              out_vs_q, out_vs_d;
  logic              out_de_q, out_de_d;
  logic              frame_start_q, frame_start_d;
  logic              line_start_q, line_start_d;

  // ---------------------------------------------------------------------------
  // Raster counters, address generation, timing stage
  // ---------------------------------------------------------------------------
  logic       x_last;
  logic       y_last;
  logic       active;
  logic       at_origin;
  logic [2:0] mode_sel;
  ctl_t       tim;

  always_comb begin
    x_last    = (x_q == X_LAST);
    y_last    = (y_q == Y_LAST);
    active    = (x_q < X_ACT) && (y_q < Y_ACT);
    at_origin = (x_q == '0) && (y_q == '0);
    // The pixel at the frame origin already uses the newly captured mode.
    mode_sel  = at_origin ? mode : mode_lat_q;

    tim       = '0;
    tim.de    = active;
    tim.hs    = (x_q >= X_HS0) && (x_q < X_HS1);
    tim.vs    = (y_q >= Y_VS0) && (y_q < Y_VS1);
    tim.fs    = active && at_origin;
    tim.ls    = active && (x_q == '0);
    tim.y0    = y_q[0];
    tim.x0    = x_q[0];
    tim.pat   = mode_sel;

    x_d         = x_q;
    y_d         = y_q;
    line_base_d = line_base_q;
    rd_addr_d   = rd_addr_q;
    mode_lat_d  = mode_lat_q;
    pipe_d      = pipe_q;
    pix_r_d     = pix_r_q;
    pix_g_d     = pix_g_q;
    pix_b_d     = pix_b_q;

    if (en) begin
      x_d = x_last ? '0 : x_q + 1'b1;
      if (x_last) begin
        y_d = y_last ? '0 : y_q + 1'b1;
        // line_base always refers to the line the counters are on.
        if (y_last) begin
          line_base_d = BASE;
        end else if (y_q < Y_ACT) begin
          line_base_d = line_base_q + STRIDE;
        end
      end
      if (active) begin
        rd_addr_d = line_base_q + ADDR_W'(x_q);
      end
      mode_lat_d = mode_sel;
      pipe_d     = {pipe_q[RD_LAT-1:0], tim};
      pix_r_d    = pix_r;
      pix_g_d    = pix_g;
      pix_b_d    = pix_b;
    end else begin
      // Synchronous clear: same state as reset, pipeline flushed.
      x_d         = '0;
      y_d         = '0;
      line_base_d = BASE;
      rd_addr_d   = '0;
      mode_lat_d  = '0;
      pipe_d      = '0;
      pix_r_d     = '0;
      pix_g_d     = '0;
      pix_b_d     = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Mosaic and output stage
  // ---------------------------------------------------------------------------
  ctl_t       o_ctl;
  logic [1:0] ch;

  always_comb begin
    o_ctl = pipe_q[RD_LAT];

    ch = CH_NONE;
    unique case (o_ctl.pat)
      3'd1: begin // RGGB
        unique case ({o_ctl.y0, o_ctl.x0})
          2'b00:   ch = CH_R;
          2'b11:   ch = CH_B;
          default: ch = CH_G;
        endcase
      end
      3'd2: begin // GRBG
        unique case ({o_ctl.y0, o_ctl.x0})
          2'b01:   ch = CH_R;
          2'b10:   ch = CH_B;
          default: ch = CH_G;
        endcase
      end
      3'd3: begin // GBRG
        unique case ({o_ctl.y0, o_ctl.x0})
          2'b01:   ch = CH_B;
          2'b10:   ch = CH_R;
          default: ch = CH_G;
        endcase
      end
      3'd4: begin // BGGR
        unique case ({o_ctl.y0, o_ctl.x0})
          2'b00:   ch = CH_B;
          2'b11:   ch = CH_R;
          default: ch = CH_G;
        endcase
      end
      default: ch = CH_NONE;
    endcase

    out_r_d       = '0;
    out_g_d       = '0;
    out_b_d       = '0;
    out_de_d      = 1'b0;
    out_hs_d      = 1'b0;
    out_vs_d      = 1'b0;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;

    if (en) begin
      out_de_d      = o_ctl.de;
      out_hs_d      = o_ctl.hs;
      out_vs_d      = o_ctl.vs;
      frame_start_d = o_ctl.de && o_ctl.fs;
      line_start_d  = o_ctl.de && o_ctl.ls;
      if (o_ctl.de) begin
        if (o_ctl.pat == 3'd0) begin
          out_r_d = pix_r_q;
          out_g_d = pix_g_q;
          out_b_d = pix_b_q;
        end else begin
          if (ch == CH_R) out_r_d = pix_r_q;
          if (ch == CH_G) out_g_d = pix_g_q;
          if (ch == CH_B) out_b_d = pix_b_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      line_base_q   <= BASE;
      rd_addr_q     <= '0;
      mode_lat_q    <= '0;
      pipe_q        <= '0;
      pix_r_q       <= '0;
      pix_g_q       <= '0;
      pix_b_q       <= '0;
      out_r_q       <= '0;
      out_g_q       <= '0;
      out_b_q       <= '0;
      out_hs_q      <= 1'b0;
      out_vs_q      <= 1'b0;
      out_de_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      line_base_q   <= line_base_d;
      rd_addr_q     <= rd_addr_d;
      mode_lat_q    <= mode_lat_d;
      pipe_q        <= pipe_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      out_r_q       <= out_r_d;
      out_g_q       <= out_g_d;
      out_b_q       <= out_b_d;
      out_hs_q      <= out_hs_d;
      out_vs_q      <= out_vs_d;
      out_de_q      <= out_de_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign rd_en       = pipe_q[0].de;
  assign rd_addr     = rd_addr_q;
  assign out_r       = out_r_q;
  assign out_g       = out_g_q;
  assign out_b       = out_b_q;
  assign out_hsync   = out_hs_q ? HS_POL : ~HS_POL;
  assign out_vsync   = out_vs_q ? VS_POL : ~VS_POL;
  assign out_de      = out_de_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule
